// File: rtl/ddr4_cmd_pkg.sv
// rtl/ddr4_cmd_pkg.sv - shared types and constants for the DDR4 command issuer
package ddr4_cmd_pkg;

   localparam int BG_W  = 2;
   localparam int BA_W  = 2;
   localparam int ROW_W = 17;
   localparam int COL_W = 10;

   // Command opcodes carried on A[16:14] (RAS_n, CAS_n, WE_n) when ACT_n is high
   localparam logic [2:0] OP_RD  = 3'b101;
   localparam logic [2:0] OP_WR  = 3'b100;
   localparam logic [2:0] OP_PRE = 3'b010;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT_RP,
      ST_ACT,
      ST_WAIT_RCD,
      ST_CAS,
      ST_WAIT_LAT,
      ST_DATA,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic             write;
      logic [BG_W-1:0]  bg;
      logic [BA_W-1:0]  ba;
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } req_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/open_row_table.sv
// rtl/open_row_table.sv - per-bank open-row register file with combinational lookup
module open_row_table
   import ddr4_cmd_pkg::*;
#(
   parameter int BGWIDTH   = BG_W,
   parameter int BAWIDTH   = BA_W,
   parameter int ADDRWIDTH = ROW_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BGWIDTH-1:0]   lookup_bg,
   input  logic [BAWIDTH-1:0]   lookup_ba,
   input  logic [ADDRWIDTH-1:0] lookup_row,
   output logic                 hit,
   output logic                 valid,
   input  logic                 set_en,
   input  logic                 clear_en,
   input  logic [BGWIDTH-1:0]   upd_bg,
   input  logic [BAWIDTH-1:0]   upd_ba,
   input  logic [ADDRWIDTH-1:0] upd_row
);

   localparam int IDXW = BGWIDTH + BAWIDTH;
   localparam int NB   = 1 << IDXW;

   logic [NB-1:0]        vld;
   logic [ADDRWIDTH-1:0] rows [NB];
   logic [IDXW-1:0]      lidx;
   logic [IDXW-1:0]      uidx;

   assign lidx  = {lookup_bg, lookup_ba};
   assign uidx  = {upd_bg, upd_ba};
   assign valid = vld[lidx];
   assign hit   = vld[lidx] && (rows[lidx] == lookup_row);

   // Only the valid bits need reset; a row value is meaningless while its bit is clear
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         if (set_en) begin
            vld[uidx]  <= 1'b1;
            rows[uidx] <= upd_row;
         end else if (clear_en) begin
            vld[uidx] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ddr4_cmd_issuer.sv
// rtl/ddr4_cmd_issuer.sv - DDR4 controller end: open-page PRE/ACT/CAS sequencing and burst data
module ddr4_cmd_issuer
   import ddr4_cmd_pkg::*;
#(
   parameter int BGWIDTH   = BG_W,
   parameter int BAWIDTH   = BA_W,
   parameter int ADDRWIDTH = ROW_W,
   parameter int COLWIDTH  = COL_W,
   parameter int DQWIDTH   = 72,
   parameter int BL        = 8,
   parameter int TRP       = 3,
   parameter int TRCD      = 3,
   parameter int CL        = 5,
   parameter int CWL       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [BGWIDTH-1:0]      req_bg,
   input  logic [BAWIDTH-1:0]      req_ba,
   input  logic [ADDRWIDTH-1:0]    req_row,
   input  logic [COLWIDTH-1:0]     req_col,
   input  logic [DQWIDTH*BL-1:0]   req_wdata,
   output logic                    rsp_valid,
   output logic                    rsp_write,
   output logic [DQWIDTH*BL-1:0]   rsp_rdata,
   output logic                    act_n,
   output logic [ADDRWIDTH-1:0]    A,
   output logic [BGWIDTH-1:0]      bg,
   output logic [BAWIDTH-1:0]      ba,
   output logic                    cs_n,
   output logic                    cke,
   output logic [DQWIDTH-1:0]      dq_o,
   output logic                    dq_oe,
   input  logic [DQWIDTH-1:0]      dq_i
);

   localparam int CNTW = $clog2(max_of(max_of(max_of(TRP, TRCD), max_of(CL, CWL)), BL) + 1);

   state_t                state, state_nxt;
   logic [CNTW-1:0]       cnt, cnt_nxt;
   logic [CNTW-1:0]       beat, beat_nxt;
   req_t                  req, req_nxt;
   logic [DQWIDTH*BL-1:0] wdata_q, rd_buf, rd_nxt;
   logic [ADDRWIDTH-1:0]  a_nxt;
   logic                  accept, row_hit, row_valid, is_cmd, drive_beat;

   assign accept     = (state == ST_IDLE) && req_ready && req_valid;
   assign is_cmd     = (state_nxt == ST_PRE) || (state_nxt == ST_ACT) || (state_nxt == ST_CAS);
   assign drive_beat = (state_nxt == ST_DATA) && req_nxt.write;
   assign beat_nxt   = (state == ST_DATA) ? beat + CNTW'(1) : '0;

   open_row_table #(
      .BGWIDTH   (BGWIDTH),
      .BAWIDTH   (BAWIDTH),
      .ADDRWIDTH (ADDRWIDTH)
   ) u_ort (
      .clk        (clk),
      .reset      (reset),
      .lookup_bg  (req_bg),
      .lookup_ba  (req_ba),
      .lookup_row (req_row),
      .hit        (row_hit),
      .valid      (row_valid),
      .set_en     (state == ST_ACT),
      .clear_en   (state == ST_PRE),
      .upd_bg     (req.bg),
      .upd_ba     (req.ba),
      .upd_row    (req.row)
   );

   // Wait states leave when the counter is about to reach 0, so the next command
   // lands exactly N cycles after the one that loaded N-1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_nxt   = req;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               req_nxt.write = req_write;
               req_nxt.bg    = req_bg;
               req_nxt.ba    = req_ba;
               req_nxt.row   = req_row;
               req_nxt.col   = req_col;
               if (row_hit)        state_nxt = ST_CAS;
               else if (row_valid) state_nxt = ST_PRE;
               else                state_nxt = ST_ACT;
            end
         end
         ST_PRE: begin
            if (TRP == 1) begin
               state_nxt = ST_ACT;
            end else begin
               state_nxt = ST_WAIT_RP;
               cnt_nxt   = CNTW'(TRP - 1);
            end
         end
         ST_WAIT_RP: begin
            cnt_nxt = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state_nxt = ST_ACT;
         end
         ST_ACT: begin
            if (TRCD == 1) begin
               state_nxt = ST_CAS;
            end else begin
               state_nxt = ST_WAIT_RCD;
               cnt_nxt   = CNTW'(TRCD - 1);
            end
         end
         ST_WAIT_RCD: begin
            cnt_nxt = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state_nxt = ST_CAS;
         end
         ST_CAS: begin
            if (req.write ? (CWL == 1) : (CL == 1)) begin
               state_nxt = ST_DATA;
            end else begin
               state_nxt = ST_WAIT_LAT;
               cnt_nxt   = req.write ? CNTW'(CWL - 1) : CNTW'(CL - 1);
            end
         end
         ST_WAIT_LAT: begin
            cnt_nxt = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (beat == CNTW'(BL - 1)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      a_nxt = '0;
      case (state_nxt)
         ST_ACT: a_nxt = req_nxt.row;
         ST_CAS: begin
            a_nxt[ADDRWIDTH-1 -: 3] = req_nxt.write ? OP_WR : OP_RD;
            a_nxt[COLWIDTH-1:0]     = req_nxt.col;
         end
         ST_PRE: a_nxt[ADDRWIDTH-1 -: 3] = OP_PRE;
         default: a_nxt = '0;
      endcase
   end

   always_comb begin
      rd_nxt = rd_buf;
      rd_nxt[beat*DQWIDTH +: DQWIDTH] = dq_i;
   end

   // Pin outputs are registered from the next state so the bus matches the state held in that cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         beat      <= '0;
         req       <= '0;
         wdata_q   <= '0;
         rd_buf    <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         cs_n      <= 1'b1;
         act_n     <= 1'b1;
         A         <= '0;
         bg        <= '0;
         ba        <= '0;
         cke       <= 1'b0;
         dq_o      <= '0;
         dq_oe     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req       <= req_nxt;
         beat      <= (state_nxt == ST_DATA) ? beat_nxt : '0;
         if (accept) wdata_q <= req_wdata;
         cke       <= 1'b1;
         req_ready <= (state_nxt == ST_IDLE);
         cs_n      <= !is_cmd;
         act_n     <= (state_nxt != ST_ACT);
         A         <= a_nxt;
         bg        <= is_cmd ? req_nxt.bg : '0;
         ba        <= is_cmd ? req_nxt.ba : '0;
         dq_oe     <= drive_beat;
         dq_o      <= drive_beat ? wdata_q[beat_nxt*DQWIDTH +: DQWIDTH] : '0;
         rsp_valid <= (state_nxt == ST_DONE);
         if (state_nxt == ST_DONE) rsp_write <= req.write;
         if ((state == ST_DATA) && !req.write) begin
            rd_buf <= rd_nxt;
            if (beat == CNTW'(BL - 1)) rsp_rdata <= rd_nxt;
         end
      end
   end

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// tb/tb_ddr4_cmd_issuer.sv - scoreboard bench for ddr4_cmd_issuer with directed requests
module tb_ddr4_cmd_issuer;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid, req_ready, req_write;
   logic [1:0]   req_bg, req_ba;
   logic [16:0]  req_row;
   logic [9:0]   req_col;
   logic [575:0] req_wdata;
   logic         rsp_valid, rsp_write;
   logic [575:0] rsp_rdata;
   logic         act_n, cs_n, cke, dq_oe;
   logic [16:0]  A;
   logic [1:0]   bg, ba;
   logic [71:0]  dq_o, dq_i;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   logic [53:0]  cmd_q[$];
   logic [103:0] beat_q[$];
   logic [103:0] drv_q[$];
   logic [608:0] rsp_q[$];
   logic [575:0] last_rd = '0;

   logic [53:0]  cgot;
   logic [103:0] bgot;
   logic [608:0] rgot;

   ddr4_cmd_issuer dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_bg    (req_bg),
      .req_ba    (req_ba),
      .req_row   (req_row),
      .req_col   (req_col),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .act_n     (act_n),
      .A         (A),
      .bg        (bg),
      .ba        (ba),
      .cs_n      (cs_n),
      .cke       (cke),
      .dq_o      (dq_o),
      .dq_oe     (dq_oe),
      .dq_i      (dq_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [639:0] got, input logic [639:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, got, exp);
   endtask

   task automatic unexpected(input string nm, input logic [639:0] got);
      n_total++;
      $display("FAIL %s: got %h required nothing", nm, got);
   endtask

   function automatic logic [53:0] cpk(input int cy, input logic an, input logic [16:0] a,
                                       input logic [1:0] g, input logic [1:0] b);
      return {32'(cy), an, a, g, b};
   endfunction

   function automatic logic [575:0] mk(input logic [7:0] seed);
      logic [575:0] d;
      for (int k = 0; k < 8; k++) d[k*72 +: 72] = {seed, 48'h0, 16'(k + 1)};
      return d;
   endfunction

   // Monitor: every bus command, write beat and response is checked against the queues
   always @(negedge clk) begin
      if (cs_n === 1'b0) begin
         cgot = {32'(cyc), act_n, A, bg, ba};
         if (cmd_q.size() == 0) unexpected("cmd", 640'(cgot));
         else chk("cmd", 640'(cgot), 640'(cmd_q.pop_front()));
      end
      if (dq_oe === 1'b1) begin
         bgot = {32'(cyc), dq_o};
         if (beat_q.size() == 0) unexpected("wbeat", 640'(bgot));
         else chk("wbeat", 640'(bgot), 640'(beat_q.pop_front()));
      end
      if (rsp_valid === 1'b1) begin
         rgot = {32'(cyc), rsp_write, rsp_rdata};
         if (rsp_q.size() == 0) unexpected("rsp", 640'(rgot));
         else chk("rsp", 640'(rgot), 640'(rsp_q.pop_front()));
      end
   end

   always @(posedge clk) begin
      #1;
      if (drv_q.size() != 0 && drv_q[0][103:72] == 32'(cyc)) begin
         dq_i = drv_q[0][71:0];
         void'(drv_q.pop_front());
      end else begin
         dq_i = 72'h0BAD0BAD0BAD0BAD0B;
      end
   end

   // kind: 0 = bank closed, 1 = other row open, 2 = row hit. Timing with TRP=TRCD=3, CL=5, CWL=4, BL=8.
   task automatic send(input bit wr, input logic [1:0] g, input logic [1:0] b, input logic [16:0] row,
                       input logic [9:0] col, input int kind, input logic [575:0] data,
                       input bit hold, input int nbeat, output int t0);
      int c;
      bit got;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = wr; req_bg = g; req_ba = b;
      req_row = row; req_col = col; req_wdata = wr ? data : '0;
      got = 1'b0;
      t0 = -1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            got = 1'b1;
            t0 = cyc;
         end
      end
      if (!got) begin
         unexpected("send_timeout", 640'(row));
         req_valid = 1'b0;
         return;
      end
      c = t0 + 1;
      if (kind == 1) begin
         cmd_q.push_back(cpk(c, 1'b1, {3'b010, 14'h0}, g, b));
         c += 3;
      end
      if (kind != 2) begin
         cmd_q.push_back(cpk(c, 1'b0, row, g, b));
         c += 3;
      end
      cmd_q.push_back(cpk(c, 1'b1, {(wr ? 3'b100 : 3'b101), 4'b0, col}, g, b));
      if (wr) begin
         for (int k = 0; k < nbeat; k++) beat_q.push_back({32'(c + 4 + k), data[k*72 +: 72]});
         if (nbeat == 8) rsp_q.push_back({32'(c + 12), 1'b1, last_rd});
      end else begin
         for (int k = 0; k < 8; k++) drv_q.push_back({32'(c + 5 + k), data[k*72 +: 72]});
         rsp_q.push_back({32'(c + 13), 1'b0, data});
         last_rd = data;
      end
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required completion");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

   initial begin
      int t, ta, tb2, c;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0;
      req_row = '0; req_col = '0; req_wdata = '0; dq_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", 640'(cs_n), 640'(1));
      chk("rst_act_n", 640'(act_n), 640'(1));
      chk("rst_A", 640'(A), 640'(0));
      chk("rst_dq_oe", 640'(dq_oe), 640'(0));
      chk("rst_rsp_valid", 640'(rsp_valid), 640'(0));
      chk("rst_req_ready", 640'(req_ready), 640'(0));
      chk("rst_cke", 640'(cke), 640'(0));
      chk("rst_rdata", 640'(rsp_rdata), 640'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("post_rst_ready", 640'(req_ready), 640'(1));
      chk("post_rst_cke", 640'(cke), 640'(1));

      send(1'b1, 2'd1, 2'd2, 17'h1ABC, 10'h010, 0, mk(8'hA0), 1'b0, 8, t);
      send(1'b0, 2'd1, 2'd2, 17'h1ABC, 10'h020, 2, mk(8'h00), 1'b0, 8, t);
      send(1'b0, 2'd1, 2'd2, 17'h0002, 10'h003, 1, mk(8'h33), 1'b0, 8, t);
      send(1'b1, 2'd0, 2'd0, 17'h0005, 10'h004, 0, mk(8'h44), 1'b0, 8, t);
      send(1'b0, 2'd1, 2'd2, 17'h1ABC, 10'h005, 1, mk(8'h55), 1'b0, 8, t);
      send(1'b0, 2'd0, 2'd0, 17'h0005, 10'h006, 2, mk(8'h66), 1'b0, 8, t);
      send(1'b0, 2'd1, 2'd2, 17'h1ABC, 10'h007, 2, mk(8'h77), 1'b0, 8, t);

      send(1'b1, 2'd0, 2'd0, 17'h0005, 10'h008, 2, mk(8'h88), 1'b1, 8, ta);
      send(1'b0, 2'd1, 2'd2, 17'h1ABC, 10'h009, 2, mk(8'h99), 1'b0, 8, tb2);
      chk("bp_accept_cycle", 640'(tb2), 640'(ta + 14));

      send(1'b1, 2'd2, 2'd1, 17'h0007, 10'h001, 0, mk(8'hBB), 1'b0, 3, t);
      c = t + 4;
      while (cyc < c + 6) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      last_rd = '0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_cs_n", 640'(cs_n), 640'(1));
      chk("abort_dq_oe", 640'(dq_oe), 640'(0));
      chk("abort_rsp_valid", 640'(rsp_valid), 640'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("abort_ready", 640'(req_ready), 640'(1));
      send(1'b0, 2'd2, 2'd1, 17'h0007, 10'h002, 0, mk(8'hCC), 1'b0, 8, t);

      for (int i = 0; i < 200 && (cmd_q.size() + beat_q.size() + rsp_q.size() + drv_q.size()) != 0; i++)
         @(negedge clk);
      repeat (4) @(negedge clk);
      chk("cmd_q_drained", 640'(cmd_q.size()), 640'(0));
      chk("beat_q_drained", 640'(beat_q.size()), 640'(0));
      chk("rsp_q_drained", 640'(rsp_q.size()), 640'(0));
      chk("drv_q_drained", 640'(drv_q.size()), 640'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
